// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared types for the instruction/data memory port arbiter: FSM state
// encoding and grant identifiers used by the arbiter and its tie-break
// selector.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_grant_select.sv
// -----------------------------------------------------------------------------
// rr_grant_select
// Two-way round-robin grant choice between instruction and data requesters.
// A lone requester always wins; on a tie the port not granted last wins.
//
// Ports
//   ireq        in   instruction-fetch request
//   dreq        in   data-access request
//   last_grant  in   port granted most recently (GRANT_I / GRANT_D)
//   grant_valid out  at least one request pending
//   grant       out  selected port (GRANT_I / GRANT_D)
// -----------------------------------------------------------------------------
module rr_grant_select (
    input  logic ireq,
    input  logic dreq,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant
);
    import mem_port_arbiter_pkg::*;

    always_comb begin
        grant_valid = ireq | dreq;
        if (ireq && dreq) begin
            grant = ~last_grant;
        end else if (dreq) begin
            grant = GRANT_D;
        end else begin
            grant = GRANT_I;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between an instruction-fetch requester and a data
// requester. One transaction at a time; ties are broken round-robin.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no transaction; arbitrate pending requests at the next edge
// IBUSY | fetch issued on memory port, waiting for mack
// DBUSY | load/store issued on memory port, waiting for mack
// DONE  | ready pulse to the granted requester, then back to IDLE
//
// Ports
//   clk, reset                 clock, async active-high reset
//   ireq/iaddr -> irdata/iready         instruction-fetch side
//   dreq/dwe/daddr/dwdata -> drdata/dready   data side
//   mreq/mwe/maddr/mwdata (registered), mrdata/mack   memory side
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ireq,
    input  logic [WIDTH-1:0] iaddr,
    output logic [WIDTH-1:0] irdata,
    output logic             iready,
    input  logic             dreq,
    input  logic             dwe,
    input  logic [WIDTH-1:0] daddr,
    input  logic [WIDTH-1:0] dwdata,
    output logic [WIDTH-1:0] drdata,
    output logic             dready,
    output logic             mreq,
    output logic             mwe,
    output logic [WIDTH-1:0] maddr,
    output logic [WIDTH-1:0] mwdata,
    input  logic [WIDTH-1:0] mrdata,
    input  logic             mack
);
    import mem_port_arbiter_pkg::*;

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             mreq_q, mreq_d;
    logic             mwe_q, mwe_d;
    logic [WIDTH-1:0] maddr_q, maddr_d;
    logic [WIDTH-1:0] mwdata_q, mwdata_d;
    logic [WIDTH-1:0] irdata_q, irdata_d;
    logic [WIDTH-1:0] drdata_q, drdata_d;
    logic             iready_q, iready_d;
    logic             dready_q, dready_d;

    logic             grant_valid;
    logic             grant;

    rr_grant_select u_rr_grant_select (
        .ireq        (ireq),
        .dreq        (dreq),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mreq_d       = mreq_q;
        mwe_d        = mwe_q;
        maddr_d      = maddr_q;
        mwdata_d     = mwdata_q;
        irdata_d     = irdata_q;
        drdata_d     = drdata_q;
        iready_d     = 1'b0;
        dready_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    last_grant_d = grant;
                    mreq_d       = 1'b1;
                    if (grant == GRANT_D) begin
                        state_d  = DBUSY;
                        mwe_d    = dwe;
                        maddr_d  = daddr;
                        mwdata_d = dwdata;
                    end else begin
                        state_d  = IBUSY;
                        mwe_d    = 1'b0;
                        maddr_d  = iaddr;
                        mwdata_d = '0;
                    end
                end
            end
            IBUSY, DBUSY: begin
                if (mack) begin
                    state_d = DONE;
                    mreq_d  = 1'b0;
                    mwe_d   = 1'b0;
                    if (state_q == DBUSY) begin
                        dready_d = 1'b1;
                        // Stores complete without disturbing the last load value.
                        if (!mwe_q) begin
                            drdata_d = mrdata;
                        end
                    end else begin
                        iready_d = 1'b1;
                        irdata_d = mrdata;
                    end
                end
            end
            DONE: begin
                // No arbitration here: the requester is still dropping its req.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
            mreq_q       <= 1'b0;
            mwe_q        <= 1'b0;
            maddr_q      <= '0;
            mwdata_q     <= '0;
            irdata_q     <= '0;
            drdata_q     <= '0;
            iready_q     <= 1'b0;
            dready_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mreq_q       <= mreq_d;
            mwe_q        <= mwe_d;
            maddr_q      <= maddr_d;
            mwdata_q     <= mwdata_d;
            irdata_q     <= irdata_d;
            drdata_q     <= drdata_d;
            iready_q     <= iready_d;
            dready_q     <= dready_d;
        end
    end

    assign mreq   = mreq_q;
    assign mwe    = mwe_q;
    assign maddr  = maddr_q;
    assign mwdata = mwdata_q;
    assign irdata = irdata_q;
    assign drdata = drdata_q;
    assign iready = iready_q;
    assign dready = dready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed scenarios with literal expectations, then randomized requesters
// and memory, all compared every cycle against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
    localparam int W = 32;

    logic         clk    = 1'b0;
    logic         reset  = 1'b1;
    logic         ireq   = 1'b0;
    logic         dreq   = 1'b0;
    logic         dwe    = 1'b0;
    logic         mack   = 1'b0;
    logic [W-1:0] iaddr  = '0;
    logic [W-1:0] daddr  = '0;
    logic [W-1:0] dwdata = '0;
    logic [W-1:0] mrdata = '0;
    logic [W-1:0] irdata, drdata, maddr, mwdata;
    logic         iready, dready, mreq, mwe;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .ireq   (ireq),
        .iaddr  (iaddr),
        .irdata (irdata),
        .iready (iready),
        .dreq   (dreq),
        .dwe    (dwe),
        .daddr  (daddr),
        .dwdata (dwdata),
        .drdata (drdata),
        .dready (dready),
        .mreq   (mreq),
        .mwe    (mwe),
        .maddr  (maddr),
        .mwdata (mwdata),
        .mrdata (mrdata),
        .mack   (mack)
    );

    // Transaction-level model: one in-flight transaction, a ready cycle after
    // it completes, and the last port that won arbitration.
    bit           t_busy, t_port, t_we;
    logic [W-1:0] t_addr, t_wdata;
    bit           fin, fin_port;
    bit           last_port;  // 0 = instruction, 1 = data
    logic [W-1:0] e_irdata, e_drdata;

    task automatic model_reset();
        t_busy = 0; t_port = 0; t_we = 0; t_addr = '0; t_wdata = '0;
        fin = 0; fin_port = 0; last_port = 0;
        e_irdata = '0; e_drdata = '0;
    endtask

    task automatic model_update();
        if (reset) begin
            model_reset();
        end else if (fin) begin
            fin = 0;
        end else if (t_busy) begin
            if (mack) begin
                if (t_port) begin
                    if (!t_we) e_drdata = mrdata;
                end else begin
                    e_irdata = mrdata;
                end
                t_busy = 0;
                fin = 1;
                fin_port = t_port;
            end
        end else if (ireq || dreq) begin
            t_port = (ireq && dreq) ? !last_port : dreq;
            last_port = t_port;
            t_busy = 1;
            if (t_port) begin
                t_addr = daddr; t_we = dwe; t_wdata = dwdata;
            end else begin
                t_addr = iaddr; t_we = 0; t_wdata = '0;
            end
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    endtask

    task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    task automatic compare_all();
        chk1("mreq", mreq, t_busy);
        chk1("mwe", mwe, t_busy && t_we);
        chk1("iready", iready, fin && !fin_port);
        chk1("dready", dready, fin && fin_port);
        chkw("irdata", irdata, e_irdata);
        chkw("drdata", drdata, e_drdata);
        if (t_busy) begin
            chkw("maddr", maddr, t_addr);
            chkw("mwdata", mwdata, t_wdata);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    int  grants;
    bit  seen;
    bit  i_inflight, d_inflight;

    initial begin
        model_reset();
        repeat (2) step();
        chk1("rst mreq", mreq, 1'b0);
        chk1("rst mwe", mwe, 1'b0);
        chkw("rst maddr", maddr, 32'h0);
        chkw("rst mwdata", mwdata, 32'h0);
        chkw("rst irdata", irdata, 32'h0);
        chkw("rst drdata", drdata, 32'h0);
        chk1("rst iready", iready, 1'b0);
        chk1("rst dready", dready, 1'b0);
        reset = 1'b0;
        step();

        // Lone fetch, zero wait cycles
        ireq = 1'b1; iaddr = 32'h00400000;
        step();
        chk1("fetch mreq", mreq, 1'b1);
        chkw("fetch maddr", maddr, 32'h00400000);
        chk1("fetch mwe", mwe, 1'b0);
        chk1("fetch early iready", iready, 1'b0);
        mack = 1'b1; mrdata = 32'h8C080004;
        step();
        chk1("fetch iready", iready, 1'b1);
        chkw("fetch irdata", irdata, 32'h8C080004);
        ireq = 1'b0; mack = 1'b0; mrdata = '0;
        step();
        chk1("fetch iready one cycle", iready, 1'b0);

        // Store with two wait cycles
        dreq = 1'b1; dwe = 1'b1; daddr = 32'h10010000; dwdata = 32'hDEADBEEF;
        for (int k = 0; k < 3; k++) begin
            step();
            chk1("store mreq held", mreq, 1'b1);
            chk1("store mwe", mwe, 1'b1);
            chkw("store maddr", maddr, 32'h10010000);
            chkw("store mwdata", mwdata, 32'hDEADBEEF);
            chk1("store early dready", dready, 1'b0);
        end
        mack = 1'b1; mrdata = 32'h12345678;
        step();
        chk1("store dready", dready, 1'b1);
        chkw("store drdata unchanged", drdata, 32'h0);
        dreq = 1'b0; dwe = 1'b0; mack = 1'b0;
        step();

        // Ties after reset: data first, then strict alternation
        reset = 1'b1;
        step();
        reset = 1'b0;
        ireq = 1'b1; dreq = 1'b1; iaddr = 32'h00400100; daddr = 32'h10010100; mack = 1'b1;
        grants = 0;
        for (int c = 0; c < 60 && grants < 6; c++) begin
            mrdata = $urandom;
            step();
            if (iready || dready) begin
                chk1($sformatf("tie order %0d", grants), dready, (grants % 2) == 0);
                grants++;
            end
            if (fin && fin_port) dreq = 1'b0; else if (!dreq) dreq = 1'b1;
            if (fin && !fin_port) ireq = 1'b0; else if (!ireq) ireq = 1'b1;
        end
        chkw("tie grant count", grants, 32'd6);
        ireq = 1'b0; dreq = 1'b0; mack = 1'b0;
        repeat (2) step();

        // Reset in the middle of a data transaction
        dreq = 1'b1; dwe = 1'b0; daddr = 32'h10010200;
        step();
        chk1("midrst busy", mreq, 1'b1);
        step();
        #2 reset = 1'b1;
        #1;
        chk1("midrst mreq", mreq, 1'b0);
        chk1("midrst mwe", mwe, 1'b0);
        chkw("midrst maddr", maddr, 32'h0);
        chkw("midrst mwdata", mwdata, 32'h0);
        chkw("midrst irdata", irdata, 32'h0);
        chkw("midrst drdata", drdata, 32'h0);
        chk1("midrst iready", iready, 1'b0);
        chk1("midrst dready", dready, 1'b0);
        step();
        reset = 1'b0;
        mack = 1'b1; mrdata = 32'hCAFEF00D;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (dready) begin
                seen = 1;
                dreq = 1'b0;
                break;
            end
        end
        chk1("post-reset dready", seen, 1'b1);
        chkw("post-reset drdata", drdata, 32'hCAFEF00D);
        mack = 1'b0;
        step();

        // Spurious mack while idle
        mack = 1'b1; mrdata = 32'hFFFFFFFF;
        repeat (3) begin
            step();
            chkw("spurious irdata", irdata, 32'h0);
            chkw("spurious drdata", drdata, 32'hCAFEF00D);
            chk1("spurious iready", iready, 1'b0);
            chk1("spurious dready", dready, 1'b0);
        end
        mack = 1'b0;

        // Randomized requesters and memory latency
        for (int c = 0; c < 3000; c++) begin
            i_inflight = (t_busy && !t_port) || (fin && !fin_port);
            d_inflight = (t_busy && t_port) || (fin && fin_port);
            if (ireq) begin
                if (fin && !fin_port) ireq = 1'b0;
                else if (t_busy && !t_port && $urandom_range(7) == 0) ireq = 1'b0;
            end else if (!i_inflight && $urandom_range(2) == 0) begin
                ireq = 1'b1; iaddr = $urandom;
            end
            if (dreq) begin
                if (fin && fin_port) dreq = 1'b0;
                else if (t_busy && t_port && $urandom_range(7) == 0) dreq = 1'b0;
            end else if (!d_inflight && $urandom_range(2) == 0) begin
                dreq = 1'b1; dwe = 1'($urandom_range(1)); daddr = $urandom; dwdata = $urandom;
            end
            mack = ($urandom_range(2) == 0);
            mrdata = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
